alu_issue_stage: RTL and testbench

- Decode-and-issue stage that sits in front of the ALU and produces its 5-bit operation code.
- Accepts a 32-bit RV32 instruction word plus register read values over a valid/ready handshake.
- Decodes R-type (opcode 0110011) and OP-IMM (opcode 0010011) instructions into {opc, op1, op2, rd}.
- Presents the result to the ALU/writeback side through a registered 2-entry skid buffer with its own valid/ready handshake.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_issue_skid.sv | 88 ++++++++
 rtl/alu_issue_stage.sv | 118 +++++++++++
 tb/tb_alu_issue_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcode/funct3 constants,
// the issue-entry layout and the skid-buffer occupancy states.
// Pure declarations; no logic, no latency, no handshake.
package alu_pkg;

  localparam int ALU_XLEN = 32;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  // One decoded instruction as handed to the ALU.
  typedef struct packed {
    logic [4:0]          opc;
    logic [ALU_XLEN-1:0] op1;
    logic [ALU_XLEN-1:0] op2;
    logic [4:0]          rd;
  } issue_entry_t;

  // Occupancy of the 2-entry skid buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  // Sign-extend a 12-bit I-type immediate to the operand width.
  function automatic logic [ALU_XLEN-1:0] sext12(input logic [11:0] imm);
    return {{(ALU_XLEN-12){imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_skid.sv
// Generic 2-entry registered skid buffer, FIFO order, head entry drives pop side.
// Latency: push to pop_valid_o is one cycle when empty; no combinational in->out path.
// Backpressure: push_ready_o is a flop, low only while both entries are occupied.
module alu_issue_skid
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_valid_i,
  output logic         push_ready_o,
  input  logic [W-1:0] push_data_i,
  output logic         pop_valid_o,
  input  logic         pop_ready_i,
  output logic [W-1:0] pop_data_o
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         ready_q, ready_d;
  logic         push_fire;
  logic         pop_fire;

  assign push_fire    = push_valid_i & ready_q;
  assign pop_fire     = (state_q != ST_EMPTY) & pop_ready_i;
  assign push_ready_o = ready_q;
  assign pop_valid_o  = (state_q != ST_EMPTY);
  assign pop_data_o   = head_q;

  // Next occupancy and entry movement; ready is precomputed from the next state
  // so the upstream sees a plain flop.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      ST_EMPTY: begin
        if (push_fire) begin
          state_d = ST_ONE;
          head_d  = push_data_i;
        end
      end
      ST_ONE: begin
        if (push_fire && pop_fire) begin
          head_d = push_data_i;
        end else if (push_fire) begin
          state_d = ST_FULL;
          tail_d  = push_data_i;
        end else if (pop_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop_fire) begin
          state_d = ST_ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    ready_d = (state_d != ST_FULL);
  end

  // Occupancy and ready registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decodes RV32 R-type / OP-IMM into {opc, op1, op2, rd} and issues via a 2-entry skid buffer.
// Latency: one cycle from accept to out_valid when empty; illegal pulses one cycle after accept.
// Backpressure: in_ready is registered and drops only while two entries are buffered.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN  = ALU_XLEN,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_opc,
  output logic [XLEN-1:0]  out_op1,
  output logic [XLEN-1:0]  out_op2,
  output logic [4:0]       out_rd,
  output logic             illegal,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic [6:0]       opcode;
  logic [2:0]       f3;
  logic             is_r;
  logic             is_i;
  logic             legal;
  logic             in_fire;
  logic             push;
  logic             drop;
  issue_entry_t     dec;
  issue_entry_t     head;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] issued_cnt_q, issued_cnt_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
  logic             unused_rs1_field;

  // Register-file source index is resolved upstream; only its value arrives here.
  assign unused_rs1_field = ^in_instr[19:15];

  assign opcode  = in_instr[6:0];
  assign f3      = in_instr[14:12];
  assign is_r    = (opcode == OPC_R);
  assign is_i    = (opcode == OPC_I);
  assign legal   = is_r | is_i;
  assign in_fire = in_valid & in_ready;
  assign push    = in_fire & legal;
  assign drop    = in_fire & ~legal;

  // Field extraction; SLLI takes a 5-bit shamt rather than a signed immediate.
  always_comb begin
    dec     = '0;
    dec.op1 = in_rs1;
    dec.rd  = in_instr[11:7];
    if (is_r) begin
      dec.opc = {in_instr[30], in_instr[25], f3};
      dec.op2 = in_rs2;
    end else begin
      dec.opc = {2'b00, f3};
      if (f3 == F3_SLL) begin
        dec.op2 = {{(XLEN-5){1'b0}}, in_instr[24:20]};
      end else begin
        dec.op2 = sext12(in_instr[31:20]);
      end
    end
  end

  // Illegal words are consumed here and never reach the buffer.
  alu_issue_skid #(
    .W($bits(issue_entry_t))
  ) u_skid (
    .clk          (clk),
    .rst          (rst),
    .push_valid_i (in_valid & legal),
    .push_ready_o (in_ready),
    .push_data_i  (dec),
    .pop_valid_o  (out_valid),
    .pop_ready_i  (out_ready),
    .pop_data_o   (head)
  );

  assign out_opc = head.opc;
  assign out_op1 = head.op1;
  assign out_op2 = head.op2;
  assign out_rd  = head.rd;

  // Event counters wrap freely; illegal is a one-cycle echo of a dropped word.
  always_comb begin
    illegal_d     = drop;
    issued_cnt_d  = issued_cnt_q;
    illegal_cnt_d = illegal_cnt_q;
    if (push) issued_cnt_d  = issued_cnt_q + CNT_W'(1);
    if (drop) illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
  end

  // Status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q     <= 1'b0;
      issued_cnt_q  <= '0;
      illegal_cnt_q <= '0;
    end else begin
      illegal_q     <= illegal_d;
      issued_cnt_q  <= issued_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign illegal     = illegal_q;
  assign issued_cnt  = issued_cnt_q;
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, skid backpressure, illegal drop, async reset.
// Inputs change 1ns after the rising edge; outputs are checked right after that.
// All expected values are hand-computed constants.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_opc;
  logic [31:0] out_op1;
  logic [31:0] out_op2;
  logic [4:0]  out_rd;
  logic        illegal;
  logic [31:0] issued_cnt;
  logic [31:0] illegal_cnt;

  int checks = 0;
  int errors = 0;

  alu_issue_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_opc     (out_opc),
    .out_op1     (out_op1),
    .out_op2     (out_op2),
    .out_rd      (out_rd),
    .illegal     (illegal),
    .issued_cnt  (issued_cnt),
    .illegal_cnt (illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    in_instr = ins;
    in_rs1   = a;
    in_rs2   = b;
  endtask

  task automatic chk_head(input string tag, input logic [4:0] opc, input logic [31:0] op1,
                          input logic [31:0] op2, input logic [4:0] rd);
    chk({tag, ".valid"}, out_valid, 1'b1);
    chk({tag, ".opc"},   out_opc,   opc);
    chk({tag, ".op1"},   out_op1,   op1);
    chk({tag, ".op2"},   out_op2,   op2);
    chk({tag, ".rd"},    out_rd,    rd);
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst.in_ready",    in_ready,    1'b1);
    chk("rst.out_valid",   out_valid,   1'b0);
    chk("rst.opc",         out_opc,     5'd0);
    chk("rst.op1",         out_op1,     32'd0);
    chk("rst.op2",         out_op2,     32'd0);
    chk("rst.rd",          out_rd,      5'd0);
    chk("rst.illegal",     illegal,     1'b0);
    chk("rst.issued_cnt",  issued_cnt,  32'd0);
    chk("rst.illegal_cnt", illegal_cnt, 32'd0);

    // ADD x3,x1,x2 with the sink stalled, then drain it
    drive(1'b1, 32'h002081B3, 32'd5, 32'd7);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    chk_head("add", 5'b00000, 32'd5, 32'd7, 5'd3);
    chk("add.issued_cnt", issued_cnt, 32'd1);
    tick();
    chk("add.hold_opc", out_opc, 5'b00000);
    chk("add.hold_op1", out_op1, 32'd5);
    out_ready = 1'b1;
    tick();
    chk("add.drained", out_valid, 1'b0);

    // SUB then MUL back-to-back with the sink ready
    drive(1'b1, 32'h402081B3, 32'd9, 32'd4);
    tick();
    chk_head("sub", 5'b10000, 32'd9, 32'd4, 5'd3);
    drive(1'b1, 32'h022081B3, 32'd6, 32'd8);
    tick();
    chk_head("mul", 5'b01000, 32'd6, 32'd8, 5'd3);
    chk("mul.in_ready", in_ready, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("mul.drained", out_valid, 1'b0);
    chk("mul.issued_cnt", issued_cnt, 32'd3);

    // OP-IMM immediates: ADDI -1, SLLI 4, SLLI with junk upper bits, SRAI 3
    drive(1'b1, 32'hFFF08193, 32'd11, 32'd0);
    tick();
    chk_head("addi", 5'b00000, 32'd11, 32'hFFFFFFFF, 5'd3);
    drive(1'b1, 32'h00409193, 32'd12, 32'd0);
    tick();
    chk_head("slli", 5'b00001, 32'd12, 32'd4, 5'd3);
    drive(1'b1, 32'hFE409193, 32'd13, 32'd0);
    tick();
    chk_head("slli_hi", 5'b00001, 32'd13, 32'd4, 5'd3);
    drive(1'b1, 32'h4030D193, 32'd14, 32'd0);
    tick();
    chk_head("srai", 5'b00101, 32'd14, 32'h00000403, 5'd3);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("imm.drained", out_valid, 1'b0);
    chk("imm.issued_cnt", issued_cnt, 32'd7);

    // Backpressure: three legal words against a stalled sink
    out_ready = 1'b0;
    drive(1'b1, 32'h002080B3, 32'd100, 32'd1);
    tick();
    chk("bp.ready_after_1", in_ready, 1'b1);
    drive(1'b1, 32'h00208133, 32'd200, 32'd2);
    tick();
    chk("bp.ready_after_2", in_ready, 1'b0);
    drive(1'b1, 32'h002081B3, 32'd300, 32'd3);
    tick();
    chk("bp.ready_held", in_ready, 1'b0);
    chk_head("bp.hold_a", 5'b00000, 32'd100, 32'd1, 5'd1);
    chk("bp.issued_cnt_full", issued_cnt, 32'd9);
    out_ready = 1'b1;
    tick();
    chk_head("bp.b", 5'b00000, 32'd200, 32'd2, 5'd2);
    chk("bp.ready_reopen", in_ready, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    chk_head("bp.c", 5'b00000, 32'd300, 32'd3, 5'd3);
    tick();
    chk("bp.drained", out_valid, 1'b0);
    chk("bp.issued_cnt", issued_cnt, 32'd10);

    // Illegal opcode into an empty buffer
    drive(1'b1, 32'h00000003, 32'd1, 32'd1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    chk("ill.pulse",       illegal,     1'b1);
    chk("ill.cnt",         illegal_cnt, 32'd1);
    chk("ill.out_valid",   out_valid,   1'b0);
    chk("ill.issued_cnt",  issued_cnt,  32'd10);
    tick();
    chk("ill.pulse_end",   illegal,     1'b0);
    chk("ill.cnt_hold",    illegal_cnt, 32'd1);

    // Illegal accept while one entry is popped on the same edge
    out_ready = 1'b0;
    drive(1'b1, 32'h002082B3, 32'd55, 32'd66);
    tick();
    chk_head("ill1.a", 5'b00000, 32'd55, 32'd66, 5'd5);
    out_ready = 1'b1;
    drive(1'b1, 32'h0000007F, 32'd0, 32'd0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    chk("ill1.empty",      out_valid,   1'b0);
    chk("ill1.pulse",      illegal,     1'b1);
    chk("ill1.cnt",        illegal_cnt, 32'd2);
    chk("ill1.issued_cnt", issued_cnt,  32'd11);
    chk("ill1.in_ready",   in_ready,    1'b1);

    // Asynchronous reset with two entries buffered
    out_ready = 1'b0;
    drive(1'b1, 32'h002080B3, 32'd1, 32'd2);
    tick();
    drive(1'b1, 32'h00208133, 32'd3, 32'd4);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    chk("ar.full_ready", in_ready,  1'b0);
    chk("ar.full_valid", out_valid, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("ar.async_valid",       out_valid,   1'b0);
    chk("ar.async_issued_cnt",  issued_cnt,  32'd0);
    chk("ar.async_illegal_cnt", illegal_cnt, 32'd0);
    chk("ar.async_op1",         out_op1,     32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("ar.in_ready",    in_ready,    1'b1);
    chk("ar.out_valid",   out_valid,   1'b0);
    chk("ar.issued_cnt",  issued_cnt,  32'd0);
    chk("ar.illegal_cnt", illegal_cnt, 32'd0);

    // Buffer still works after reset
    out_ready = 1'b1;
    drive(1'b1, 32'h402081B3, 32'd20, 32'd5);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    chk_head("post", 5'b10000, 32'd20, 32'd5, 5'd3);
    chk("post.issued_cnt", issued_cnt, 32'd1);
    tick();
    chk("post.drained", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
